// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Shared glyph constants, BCD codes, FSM state type and small
//             one-hot helpers for the 7-segment reader.
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment glyphs, bit 6 = a ... bit 0 = g, matching the decoder outputs.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_6_ALT = 7'h1F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_9_ALT = 7'h73;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-decimal BCD codes reported for a dark digit and for garbage.
    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    // Capture FSM: TRACK waits for a stable window, LOCK waits for a change.
    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,
        ST_LOCK  = 1'b1
    } state_t;

    // True when exactly one bit of v is set (zero is not one-hot).
    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Position of the set bit of a one-hot vector (highest set bit otherwise).
    function automatic logic [2:0] onehot_idx8(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_reader_if
//  Brief    : Pin-side inputs and event/bank outputs of the 7-segment reader.
//             master = environment driving the pins, slave = the reader.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg7_reader_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   dig_sel;
    logic              out_ready;
    logic              clr;
    logic              out_valid;
    logic [2:0]        out_idx;
    logic [3:0]        out_bcd;
    logic              out_err;
    logic [4*NDIG-1:0] digits;
    logic              ovf;

    modport master (
        output seg, dig_sel, out_ready, clr,
        input  out_valid, out_idx, out_bcd, out_err, digits, ovf
    );

    modport slave (
        input  seg, dig_sel, out_ready, clr,
        output out_valid, out_idx, out_bcd, out_err, digits, ovf
    );
endinterface
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_encode
//  Brief    : Combinational 7-segment pattern to BCD encoder. Unknown
//             patterns yield BCD_ERR with the error flag set.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_encode
    import seg7_pkg::*;
(
    input  wire logic [6:0] i_seg,
    output logic      [3:0] o_bcd,
    output logic            o_err
);

    // Table lookup; both common renderings of 6 and 9 are accepted.
    always_comb begin
        o_bcd = BCD_ERR;
        o_err = 1'b1;
        case (i_seg)
            SEG_0:     begin o_bcd = 4'd0;      o_err = 1'b0; end
            SEG_1:     begin o_bcd = 4'd1;      o_err = 1'b0; end
            SEG_2:     begin o_bcd = 4'd2;      o_err = 1'b0; end
            SEG_3:     begin o_bcd = 4'd3;      o_err = 1'b0; end
            SEG_4:     begin o_bcd = 4'd4;      o_err = 1'b0; end
            SEG_5:     begin o_bcd = 4'd5;      o_err = 1'b0; end
            SEG_6:     begin o_bcd = 4'd6;      o_err = 1'b0; end
            SEG_6_ALT: begin o_bcd = 4'd6;      o_err = 1'b0; end
            SEG_7:     begin o_bcd = 4'd7;      o_err = 1'b0; end
            SEG_8:     begin o_bcd = 4'd8;      o_err = 1'b0; end
            SEG_9:     begin o_bcd = 4'd9;      o_err = 1'b0; end
            SEG_9_ALT: begin o_bcd = 4'd9;      o_err = 1'b0; end
            SEG_BLANK: begin o_bcd = BCD_BLANK; o_err = 1'b0; end
            default:   begin o_bcd = BCD_ERR;   o_err = 1'b1; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_reader.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_reader
//  Brief    : Samples a multiplexed N-digit 7-segment bus, debounces it,
//             decodes each settled digit to BCD, keeps a per-digit bank and
//             reports changed digits through a valid/ready event port.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE     = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    seg7_reader_if.slave  bus
);

    localparam int              c_word_w  = NDIG + 7;
    localparam int              c_cnt_w   = $clog2(STABLE + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_cap = c_cnt_w'(STABLE - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    // Input path
    logic [c_word_w-1:0] r_sync1;
    logic [c_word_w-1:0] r_sync2;
    logic [c_word_w-1:0] r_prev;
    logic [c_word_w-1:0] w_word;
    logic [NDIG-1:0]     w_sel;
    logic [6:0]          w_seg;
    logic                w_same;
    logic                w_onehot;
    logic [2:0]          w_idx;

    // Capture control
    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                w_capture;

    // Decode and event generation
    logic [3:0]          w_bcd;
    logic                w_err;
    logic [3:0]          w_old;
    logic                w_event;
    logic                w_drop;

    // Output registers
    logic                r_out_valid;
    logic [2:0]          r_out_idx;
    logic [3:0]          r_out_bcd;
    logic                r_out_err;
    logic [4*NDIG-1:0]   r_digits;
    logic                r_ovf;

    // Two-flop synchroniser for the asynchronous display pins, plus the
    // one-sample history used to detect changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {bus.dig_sel, bus.seg};
            r_sync2 <= r_sync1;
            r_prev  <= w_word;
        end
    end

    // Polarity is normalised after the synchroniser so metastability
    // handling sees the raw pins.
    assign w_word   = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    assign w_sel    = w_word[c_word_w-1:7];
    assign w_seg    = w_word[6:0];
    assign w_same   = (w_word == r_prev);
    assign w_onehot = is_onehot8(8'(w_sel));
    assign w_idx    = onehot_idx8(8'(w_sel));

    // A pattern is taken exactly once: when its run of identical samples
    // reaches the window length while still tracking.
    assign w_capture = (r_state == ST_TRACK) && w_same && w_onehot &&
                       (r_cnt == c_cnt_cap);

    // Stability counter and TRACK/LOCK state; the counter saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_TRACK;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_TRACK: begin
                    if (!w_same || !w_onehot) begin
                        r_cnt <= c_cnt_one;
                    end else begin
                        if (r_cnt != c_cnt_max) r_cnt <= r_cnt + c_cnt_one;
                        if (r_cnt == c_cnt_cap) r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (!w_same) begin
                        r_cnt   <= c_cnt_one;
                        r_state <= ST_TRACK;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= ST_TRACK;
                    r_cnt   <= c_cnt_one;
                end
            endcase
        end
    end

    seg7_encode u_encode (
        .i_seg (w_seg),
        .o_bcd (w_bcd),
        .o_err (w_err)
    );

    // Current bank value of the digit being captured.
    always_comb begin
        w_old = BCD_BLANK;
        for (int i = 0; i < NDIG; i++) begin
            if (w_sel[i]) w_old = r_digits[4*i +: 4];
        end
    end

    // Errors are always reported so a repeated bad glyph is not silent.
    assign w_event = w_capture && ((w_bcd != w_old) || w_err);
    assign w_drop  = w_event && r_out_valid && !bus.out_ready;

    // Digit bank and sticky overflow; a capture overrides clr for its digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= {NDIG{BCD_BLANK}};
            r_ovf    <= 1'b0;
        end else begin
            if (bus.clr) begin
                r_digits <= {NDIG{BCD_BLANK}};
                r_ovf    <= 1'b0;
            end
            if (w_capture) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (w_sel[i]) r_digits[4*i +: 4] <= w_bcd;
                end
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Single-entry event register; a new event may replace one being
    // accepted on the same edge, otherwise it is dropped while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= 3'd0;
            r_out_bcd   <= 4'd0;
            r_out_err   <= 1'b0;
        end else if (w_event && !w_drop) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_idx;
            r_out_bcd   <= w_bcd;
            r_out_err   <= w_err;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_bcd   = r_out_bcd;
    assign bus.out_err   = r_out_err;
    assign bus.digits    = r_digits;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seg7_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_reader
//  Brief    : Self-checking bench for seg7_reader (NDIG=4, STABLE=4,
//             active-high pins) with a run-length reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_reader;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_reader_if #(.NDIG(NDIG)) bus ();

    seg7_reader #(
        .NDIG       (NDIG),
        .STABLE     (STABLE),
        .ACTIVE_LOW (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    // Reference model state: the pins reach the filter two samples late, and
    // a digit is taken when its run of identical samples hits STABLE.
    logic [10:0] d1, d2, last_w;
    int          run;
    logic [3:0]  m_dig [NDIG];
    logic        m_v, m_err, m_ovf;
    logic [2:0]  m_idx;
    logic [3:0]  m_bcd;

    logic [6:0]  glyphs [13] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F,
                                 7'h1F, 7'h70, 7'h7F, 7'h7B, 7'h73, 7'h00};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {bcd, err} for a segment pattern, from the decoder's glyph table.
    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        case (s)
            7'h7E: return {4'd0, 1'b0};
            7'h30: return {4'd1, 1'b0};
            7'h6D: return {4'd2, 1'b0};
            7'h79: return {4'd3, 1'b0};
            7'h33: return {4'd4, 1'b0};
            7'h5B: return {4'd5, 1'b0};
            7'h5F, 7'h1F: return {4'd6, 1'b0};
            7'h70: return {4'd7, 1'b0};
            7'h7F: return {4'd8, 1'b0};
            7'h7B, 7'h73: return {4'd9, 1'b0};
            7'h00: return {4'hF, 1'b0};
            default: return {4'hE, 1'b1};
        endcase
    endfunction

    function automatic logic [15:0] m_pack();
        logic [15:0] r;
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    task automatic model_reset();
        d1 = '0; d2 = '0; last_w = '0; run = 0;
        for (int i = 0; i < NDIG; i++) m_dig[i] = 4'hF;
        m_v = 1'b0; m_idx = 3'd0; m_bcd = 4'd0; m_err = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"},  32'(bus.out_valid), 32'(m_v));
        chk({tag, ".idx"},    32'(bus.out_idx),   32'(m_idx));
        chk({tag, ".bcd"},    32'(bus.out_bcd),   32'(m_bcd));
        chk({tag, ".err"},    32'(bus.out_err),   32'(m_err));
        chk({tag, ".digits"}, 32'(bus.digits),    32'(m_pack()));
        chk({tag, ".ovf"},    32'(bus.ovf),       32'(m_ovf));
    endtask

    // Advance the model with the inputs present now, clock once, compare.
    task automatic step(input string tag);
        logic [10:0] w;
        logic [3:0]  sel, nb;
        logic [4:0]  dec;
        logic        cap, ev, er;
        int          idx;
        if (rst) begin
            model_reset();
        end else begin
            if (bus.out_valid && bus.out_ready) hs_count++;
            w = d2; d2 = d1; d1 = {bus.dig_sel, bus.seg};
            if (w == last_w) run++; else run = 1;
            last_w = w;
            sel = w[10:7];
            cap = (run == STABLE) && ($countones(sel) == 1);
            ev = 1'b0; nb = 4'd0; er = 1'b0; idx = 0;
            if (cap) begin
                for (int i = 0; i < NDIG; i++) if (sel[i]) idx = i;
                dec = ref_decode(w[6:0]);
                nb  = dec[4:1];
                er  = dec[0];
                ev  = (nb != m_dig[idx]) || er;
            end
            if (bus.clr) begin
                for (int i = 0; i < NDIG; i++) m_dig[i] = 4'hF;
                m_ovf = 1'b0;
            end
            if (cap) m_dig[idx] = nb;
            if (ev) begin
                if (m_v && !bus.out_ready) m_ovf = 1'b1;
                else begin
                    m_v = 1'b1; m_idx = 3'(idx); m_bcd = nb; m_err = er;
                end
            end else if (m_v && bus.out_ready) begin
                m_v = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] s, input int n, input string tag);
        bus.dig_sel = sel;
        bus.seg     = s;
        for (int k = 0; k < n; k++) step(tag);
    endtask

    initial begin
        bus.seg = 7'h00; bus.dig_sel = 4'b0000; bus.out_ready = 1'b0; bus.clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid",  32'(bus.out_valid), 32'd0);
        chk("rst.idx",    32'(bus.out_idx),   32'd0);
        chk("rst.bcd",    32'(bus.out_bcd),   32'd0);
        chk("rst.err",    32'(bus.out_err),   32'd0);
        chk("rst.digits", 32'(bus.digits),    32'hFFFF);
        chk("rst.ovf",    32'(bus.ovf),       32'd0);
        rst = 1'b0;

        // First capture: valid rises on the sixth edge.
        bus.dig_sel = 4'b0010; bus.seg = 7'h6D;
        for (int e = 1; e <= 6; e++) begin
            step("lat");
            if (e == 5) chk("lat.early", 32'(bus.out_valid), 32'd0);
        end
        chk("lat.valid", 32'(bus.out_valid), 32'd1);
        chk("lat.idx",   32'(bus.out_idx),   32'd1);
        chk("lat.bcd",   32'(bus.out_bcd),   32'd2);
        chk("lat.err",   32'(bus.out_err),   32'd0);
        chk("lat.dig1",  32'(bus.digits[7:4]), 32'd2);

        // Long hold and a one-sample glitch yield no further event.
        bus.out_ready = 1'b1;
        hs_count = 0;
        hold(4'b0010, 7'h6D, 50, "hold");
        chk("hold.events", 32'(hs_count), 32'd1);
        hold(4'b0010, 7'h00, 1, "glitch");
        hold(4'b0010, 7'h6D, 12, "reglitch");
        chk("glitch.events", 32'(hs_count), 32'd1);

        // Changes faster than the window are never captured.
        for (int k = 0; k < 6; k++) hold(4'b0001, glyphs[1 + (k % 3)], 3, "fast");
        chk("fast.digits", 32'(bus.digits), 32'hFF2F);
        chk("fast.events", 32'(hs_count), 32'd1);

        // Alternate 6 glyph is the same value; bad glyph always reports.
        hold(4'b0001, 7'h1F, 10, "six");
        chk("six.dig0", 32'(bus.digits[3:0]), 32'd6);
        hold(4'b0001, 7'h5F, 10, "six_alt");
        chk("six.events", 32'(hs_count), 32'd2);
        hold(4'b0001, 7'h41, 10, "bad");
        chk("bad.dig0", 32'(bus.digits[3:0]), 32'hE);
        chk("bad.events", 32'(hs_count), 32'd3);

        // Back-pressure: first event held, second dropped with overflow.
        bus.out_ready = 1'b0;
        hold(4'b0001, 7'h30, 10, "bp1");
        hold(4'b0100, 7'h7F, 10, "bp2");
        chk("bp.ovf",   32'(bus.ovf),          32'd1);
        chk("bp.dig2",  32'(bus.digits[11:8]), 32'd8);
        chk("bp.idx",   32'(bus.out_idx),      32'd0);
        chk("bp.bcd",   32'(bus.out_bcd),      32'd1);
        bus.out_ready = 1'b1;
        step("bp.accept");
        chk("bp.drain", 32'(bus.out_valid), 32'd0);
        bus.clr = 1'b1;
        step("clr");
        bus.clr = 1'b0;
        chk("clr.ovf",    32'(bus.ovf),    32'd0);
        chk("clr.digits", 32'(bus.digits), 32'hFFFF);
        hold(4'b0100, 7'h7F, 4, "clr.hold");

        // Asynchronous reset mid-count, then while an event is pending.
        bus.out_ready = 1'b0;
        hold(4'b1000, 7'h7E, 3, "midcnt");
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("arst1");
        step("arst1.hold");
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step("restart");
            if (e == 5) chk("restart.early", 32'(bus.out_valid), 32'd0);
        end
        chk("restart.valid", 32'(bus.out_valid), 32'd1);
        chk("restart.bcd",   32'(bus.out_bcd),   32'd0);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("arst2");
        chk("arst2.valid", 32'(bus.out_valid), 32'd0);
        step("arst2.hold");
        rst = 1'b0;

        // Randomised traffic against the model.
        for (int t = 0; t < 250; t++) begin
            int r, rs, n;
            r  = int'($urandom_range(0, 15));
            bus.seg = (r < 13) ? glyphs[r] : 7'($urandom);
            rs = int'($urandom_range(0, 9));
            if (rs < 8)       bus.dig_sel = 4'(1 << (rs % 4));
            else if (rs == 8) bus.dig_sel = 4'b0000;
            else              bus.dig_sel = 4'($urandom);
            n = int'($urandom_range(1, 9));
            for (int k = 0; k < n; k++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                bus.clr = (!m_v && ($urandom_range(0, 15) == 0)) ? 1'b1 : 1'b0;
                step("rand");
                bus.clr = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Receive-side counterpart of the BCD-to-7-segment decoder: samples a multiplexed N-digit 7-segment bus and recovers one BCD value per digit.
- Synchronises the external lines and debounces them over a stability window.
- Encodes the settled pattern to BCD, keeps a per-digit register bank, and reports each changed digit through a valid/ready handshake.
- Sits between external display pins and the team's logging/compare logic.

Parameters:
- NDIG, 4: number of multiplexed digits (dig_sel width), 1..8.
- STABLE, 4: consecutive identical synchronised samples required before capture, 2..255.
- ACTIVE_LOW, 0: 1 = seg and dig_sel pins are active-low; inverted right after the synchroniser.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg  in  7  segment lines {a,b,c,d,e,f,g}, seg[6]=a … seg[0]=g, same order as the decoder outputs.
- dig_sel  in  NDIG  digit enables; must be one-hot to be accepted.
- out_ready  in  1  consumer accepts the current event.
- clr  in  1  synchronous clear of ovf and of the digit bank.
- out_valid  out  1  event pending.
- out_idx  out  3  digit index of the event.
- out_bcd  out  4  decoded value: 0–9, or 4'hF = blank.
- out_err  out  1  pattern was not a legal glyph.
- digits  out  4*NDIG  current value per digit; digit i is at [4i+3:4i].
- ovf  out  1  sticky: an event was dropped.

Behaviour:
- Reset values: out_valid=0, out_idx=0, out_bcd=0, out_err=0, ovf=0, every digits nibble=4'hF. Sync flops, counter and FSM are cleared.
- Input path:
  - {dig_sel,seg} passes through a 2-flop synchroniser, then optional inversion, giving word w.
  - prev holds the previous w.
- FSM states: TRACK, LOCK.
- TRACK:
  - If w != prev, or dig_sel is not one-hot (including all zero): cnt <= 1.
  - Otherwise cnt increments.
  - When cnt reaches STABLE-1 and w == prev, capture, then go to LOCK.
- LOCK:
  - Stays in LOCK while w == prev.
  - Any change sets cnt=1 and returns to TRACK. The same pattern is never captured twice without an intervening change.
- Capture:
  - Encode seg to {bcd, err}.
  - Legal codes: 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F or 1F→6, 70→7, 7F→8, 7B or 73→9, 00→F (blank).
  - Any other code gives bcd=4'hE, err=1.
  - The digit index is the position of the set dig_sel bit.
  - digits[idx] is updated on every capture.
  - An event is raised only if the new value differs from the old digits[idx] nibble, or if err=1.
- Latency: with a steady new pattern, out_valid rises on the (STABLE+2)th rising edge after the first edge that samples it.
- Handshake:
  - out_valid stays high and out_idx/out_bcd/out_err hold until the edge on which out_valid & out_ready.
  - out_valid drops on that edge unless a new event is loaded on the same edge; in that case valid stays 1 and the data updates.
  - If an event arrives while out_valid=1 and out_ready=0, the event is dropped and ovf<=1. digits is still updated.
- clr: ovf<=0 and digits<=all F. FSM and the handshake register are unaffected. If clr coincides with a capture, the capture's nibble wins for its digit.
- Reset mid-operation: async return to the reset values; any pending event is lost.
- cnt is $clog2(STABLE+1) bits wide and saturates; it never wraps.

Decomposition:
- Package seg7_pkg holds:
  - the segment glyph constants (SEG_0..SEG_9, SEG_6_ALT, SEG_9_ALT, SEG_BLANK);
  - BCD_BLANK=4'hF and BCD_ERR=4'hE;
  - the FSM state enum.
- One combinational sub-module, seg7_encode: seg[6:0] → {bcd[3:0], err}. It is also unit-testable against the decoder's output table.

Test Plan (NDIG=4, STABLE=4, ACTIVE_LOW=0):
- Reset, then dig_sel=0010, seg=7'h6D held → out_valid=1 on edge 6, out_idx=1, out_bcd=2, out_err=0, digits[7:4]=2.
- Same pattern held a further 50 cycles with out_ready=1 → exactly one event; hold it again after a 1-cycle glitch to seg=7'h00 → still no new event, because the value is unchanged.
- Pattern changes every 3 cycles (shorter than STABLE) → no capture, digits unchanged.
- seg=7'h1F on digit 0, then 7'h5F → one event (bcd=6), the second gives no event; seg=7'h41 → event with bcd=E, err=1.
- out_ready=0 while digits 0 then 2 change → first event held, second dropped, ovf=1, digits[11:8] updated; out_ready=1 → handshake completes, then clr → ovf=0, digits=16'hFFFF.
- rst asserted mid-count and while out_valid=1 → outputs return to reset values immediately (async); capture restarts from cnt=1.
